match_fsm: RTL

Match controller for the pong design. It owns the game flow from start screen through serve, rally, point scoring and game over. It consumes the debounced start pulse, a per-frame tick from the VGA timing, and point pulses from the ball logic. It produces the run/freeze controls for the ball, the serve trigger and direction, the two score counters that feed the 7-segment and on-screen score display, and the game-over indication used by the RGB mux.

---
 rtl/match_fsm.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/match_fsm.sv
// Pong match controller: start screen, serve countdown, rally, scoring and game over.
// Optional MATCH_AUTO_RESTART_EN returns GAME_OVER to IDLE after RESTART_DELAY frames.
module match_fsm #(
  parameter int WIN_SCORE     = 3,
  parameter int SERVE_DELAY   = 60,
  parameter int RESTART_DELAY = 180
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic       game_run,
  output logic       ball_en,
  output logic       serve,
  output logic       serve_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic       gamestop
);

  typedef enum logic [2:0] {
    S_IDLE, S_SERVE_WAIT, S_PLAY, S_PAUSE, S_GAME_OVER
  } state_t;

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY - 1);

  if (WIN_SCORE < 1 || WIN_SCORE > 9 || SERVE_DELAY < 1 || SERVE_DELAY > 255 ||
      RESTART_DELAY < 1 || RESTART_DELAY > 255) begin : g_param_chk
    $error("match_fsm: parameter out of range");
  end

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  logic [3:0] p1_inc, p2_inc;
  logic [1:0] win_q, win_d;
  logic       dir_q, dir_d;
  logic       run_q, run_d;
  logic       ben_q, ben_d;
  logic       serve_q, serve_d;
  logic       stop_q, stop_d;

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    dir_d   = dir_q;
    p1_inc  = p1_q + 4'd1;
    p2_inc  = p2_q + 4'd1;
    case (state_q)
      S_IDLE: begin
        p1_d  = '0;
        p2_d  = '0;
        win_d = 2'b00;
        if (start) begin
          state_d = S_SERVE_WAIT;
          dir_d   = 1'b0;
        end
      end
      S_SERVE_WAIT: begin
        if (frame_tick && cnt_q == SERVE_LAST) state_d = S_PLAY;
      end
      S_PLAY: begin
        // A point always wins over start; a double point is a void rally.
        if (p1_point && p2_point) begin
          state_d = S_SERVE_WAIT;
        end else if (p1_point) begin
          p1_d  = p1_inc;
          dir_d = 1'b0;
          if (p1_inc == WIN) begin
            state_d = S_GAME_OVER;
            win_d   = 2'b01;
          end else begin
            state_d = S_SERVE_WAIT;
          end
        end else if (p2_point) begin
          p2_d  = p2_inc;
          dir_d = 1'b1;
          if (p2_inc == WIN) begin
            state_d = S_GAME_OVER;
            win_d   = 2'b10;
          end else begin
            state_d = S_SERVE_WAIT;
          end
        end else if (start) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start) state_d = S_PLAY;
      end
      S_GAME_OVER: begin
        if (start) begin
          state_d = S_SERVE_WAIT;
          p1_d    = '0;
          p2_d    = '0;
          win_d   = 2'b00;
          dir_d   = 1'b0;
        end
`ifdef MATCH_AUTO_RESTART_EN
        else if (frame_tick && cnt_q == 8'(RESTART_DELAY - 1)) begin
          state_d = S_IDLE;
          p1_d    = '0;
          p2_d    = '0;
          win_d   = 2'b00;
          dir_d   = 1'b0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // The counter restarts on every state change, so a tick in the transition cycle is dropped.
    cnt_d   = (state_d != state_q) ? 8'd0 : cnt_q + {7'd0, frame_tick};
    run_d   = (state_d == S_SERVE_WAIT) || (state_d == S_PLAY) || (state_d == S_PAUSE);
    ben_d   = (state_d == S_PLAY);
    serve_d = (state_q == S_SERVE_WAIT) && (state_d == S_PLAY);
    stop_d  = (state_d == S_GAME_OVER) && (state_q != S_GAME_OVER);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      win_q   <= 2'b00;
      dir_q   <= 1'b0;
      run_q   <= 1'b0;
      ben_q   <= 1'b0;
      serve_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      win_q   <= win_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
      ben_q   <= ben_d;
      serve_q <= serve_d;
      stop_q  <= stop_d;
    end
  end

  assign game_run  = run_q;
  assign ball_en   = ben_q;
  assign serve     = serve_q;
  assign serve_dir = dir_q;
  assign p1_score  = p1_q;
  assign p2_score  = p2_q;
  assign winner    = win_q;
  assign gamestop  = stop_q;

endmodule
